// File: rtl/alu_pkg.sv
// Shared opcodes, 1-bit slice operation selects and sequencer state encoding
// for the bit-serial ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [2:0] SEL_AND  = 3'b000;
  localparam logic [2:0] SEL_OR   = 3'b001;
  localparam logic [2:0] SEL_SUM  = 3'b010;
  localparam logic [2:0] SEL_LESS = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Undefined opcodes collapse to AND so the slice never sees a half-decoded op.
  function automatic logic [2:0] norm_op(input logic [2:0] op);
    logic [2:0] r;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: r = op;
      default:                               r = OP_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ALUbit.sv
// One-bit ALU slice: AND/OR on raw operands, full adder with optional
// B inversion, and a pass-through 'less' input for SLT chains.
module ALUbit
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       bitInvert,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic       dataOut,
  output logic       set,
  output logic       cout
);

  logic b_eff;
  logic sum;

  always_comb begin
    b_eff = b ^ bitInvert;
    sum   = a ^ b_eff ^ cin;
    cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
    set   = sum;
    case (op)
      SEL_AND:  dataOut = a & b;
      SEL_OR:   dataOut = a | b;
      SEL_SUM:  dataOut = sum;
      SEL_LESS: dataOut = less;
      default:  dataOut = a & b;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: feeds one ALUbit slice LSB first and rebuilds the
// WIDTH-bit result plus carry, overflow and zero flags.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid here are pure decodes of the registered state.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [2:0] op_in;
  logic       slice_out;
  logic       slice_set;
  logic       slice_cout;
  logic       is_arith;
  logic       is_slt;

  ALUbit u_bit (
    .a         (a_sh_q[0]),
    .b         (b_sh_q[0]),
    .bitInvert (op_q[2]),
    .cin       (carry_q),
    .less      (1'b0),
    .op        ({1'b0, op_q[1:0]}),
    .dataOut   (slice_out),
    .set       (slice_set),
    .cout      (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    op_in    = norm_op(op);
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    is_slt   = (op_q == OP_SLT);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d  = ST_RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          op_d     = op_in;
          carry_d  = op_in[2];
          cnt_d    = '0;
          result_d = '0;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        result_d = {slice_out, result_q[WIDTH-1:1]};
        carry_d  = slice_cout;
        cnt_d    = cnt_q + 1'b1;
        // On the MSB cycle carry_q is still the carry into the MSB.
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          if (is_slt) result_d = {{(WIDTH-1){1'b0}}, slice_set};
          cout_d  = (is_arith || is_slt) ? slice_cout : 1'b0;
          ovf_d   = is_arith ? (carry_q ^ slice_cout) : 1'b0;
          zero_d  = (result_d == '0);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      op_q     <= OP_AND;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq at WIDTH=32 with hand-computed results,
// flags, latency, backpressure and mid-run reset.
module tb_alu_serial_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [2:0]   op_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  int n_tests = 0;
  int n_fail  = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .op        (op_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: offer one operation and complete the accept edge
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] opv);
    @(negedge clk);
    check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    a_i      = av;
    b_i      = bv;
    op_i     = opv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_i      = $urandom;
    b_i      = $urandom;
    op_i     = 3'($urandom_range(0, 7));
  endtask

  // count cycles from the accept edge until out_valid, bounded
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 3 * W) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(W));
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] er, input logic ec,
                           input logic eo, input logic ez);
    check({tag, "_valid"},    {63'd0, out_valid}, 64'd1);
    check({tag, "_result"},   64'(result),        64'(er));
    check({tag, "_cout"},     {63'd0, cout},      {63'd0, ec});
    check({tag, "_overflow"}, {63'd0, overflow},  {63'd0, eo});
    check({tag, "_zero"},     {63'd0, zero},      {63'd0, ez});
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_ready_back"}, {63'd0, in_ready},  64'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2:0] opv, input logic [W-1:0] er, input logic ec,
                        input logic eo, input logic ez);
    start_op(av, bv, opv);
    wait_done(tag);
    check_out(tag, er, ec, eo, ez);
    release_out(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_i       = '0;
    b_i       = '0;
    op_i      = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result",    64'(result),        64'd0);
    check("rst_flags",     {61'd0, cout, overflow, zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_eq",    32'd5,         32'd5,         3'b110, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("slt_neg",   32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    run_op("slt_pos",   32'd3,         32'd2,         3'b111, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("and",       32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
    run_op("or",        32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b001, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    run_op("bad_op",    32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);

    // backpressure: results hold while a new offer waits
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 3'b010);
    wait_done("bp1");
    @(negedge clk);
    in_valid = 1'b1;
    a_i      = 32'd10;
    b_i      = 32'd4;
    op_i     = 3'b110;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_out("bp_hold", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_valid_drop", {63'd0, out_valid}, 64'd0);
    check("bp_ready_back", {63'd0, in_ready},  64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_second_accepted", {63'd0, in_ready}, 64'd0);
    wait_done("bp2");
    check_out("bp2", 32'd6, 1'b1, 1'b0, 1'b0);
    release_out("bp2");

    // reset pulse mid-run
    start_op(32'hFFFF_0000, 32'h0000_FFFF, 3'b010);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_in_ready",  {63'd0, in_ready},  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_stale_valid", {63'd0, out_valid}, 64'd0);
    end
    run_op("add_after_rst", 32'd2, 32'd3, 3'b010, 32'd5, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
